// File: rtl/f1_pkg.sv
`default_nettype none
// f1_pkg: shared types and default sizing for the F1 reaction timer and display path.
// Revision: 1.0
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    TIMING = 2'd2,
    DONE   = 2'd3
  } rt_state_t;

  localparam int F1_CNT_W      = 11;
  localparam int F1_TIMEOUT_MS = 1999;

endpackage
`default_nettype wire

// File: rtl/f1_reaction_timer_if.sv
`default_nettype none
// f1_reaction_timer_if: light-controller/driver inputs and result outputs of the reaction timer.
// Revision: 1.0
interface f1_reaction_timer_if
  import f1_pkg::*;
#(
  parameter int CNT_W = F1_CNT_W
);
  logic             tick;
  logic             seq_start;
  logic             lights_out;
  logic             button;
  logic             clear_best;
  logic             armed;
  logic             result_valid;
  logic             jump_start;
  logic             timeout;
  logic [CNT_W-1:0] reaction_ms;
  logic [CNT_W-1:0] best_ms;
  logic             new_best;

  modport master (
    output tick, seq_start, lights_out, button, clear_best,
    input  armed, result_valid, jump_start, timeout, reaction_ms, best_ms, new_best
  );

  modport slave (
    input  tick, seq_start, lights_out, button, clear_best,
    output armed, result_valid, jump_start, timeout, reaction_ms, best_ms, new_best
  );
endinterface
`default_nettype wire

// File: rtl/f1_button_sync.sv
`default_nettype none
// f1_button_sync: two-flop synchronizer plus rising-edge detect; one press pulse per button edge.
// Revision: 1.0
module f1_button_sync (
  input  wire logic sysclk,
  input  wire logic rst_n,
  input  wire logic button,
  output logic      press
);
  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= button;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign press = sync_q & ~prev_q;
endmodule
`default_nettype wire

// File: rtl/f1_reaction_timer.sv
`default_nettype none
// f1_reaction_timer: arms on a light sequence, flags jump starts, measures ms reaction time and tracks the best.
// Revision: 1.0
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int TIMEOUT_MS = F1_TIMEOUT_MS,
  parameter int CNT_W      = F1_CNT_W
) (
  input  wire logic           sysclk,
  input  wire logic           rst_n,
  f1_reaction_timer_if.slave  bus
);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_MS);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(TIMEOUT_MS - 1);

  rt_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reaction_q, reaction_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic             jump_q, jump_d;
  logic             timeout_q, timeout_d;
  logic             new_best_q, new_best_d;
  logic             arm;
  logic             press;

  f1_button_sync u_sync (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .button (bus.button),
    .press  (press)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reaction_d = reaction_q;
    best_d     = best_q;
    jump_d     = jump_q;
    timeout_d  = timeout_q;
    new_best_d = 1'b0;
    arm        = 1'b0;

    unique case (state_q)
      IDLE: arm = bus.seq_start;
      ARMED: begin
        if (bus.seq_start) begin
          arm = 1'b1;
        end else if (press) begin
          // press outranks a coincident lights_out: still a jump start
          state_d    = DONE;
          jump_d     = 1'b1;
          reaction_d = '0;
        end else if (bus.lights_out) begin
          state_d = TIMING;
          count_d = '0;
        end
      end
      TIMING: begin
        if (bus.seq_start) begin
          arm = 1'b1;
        end else if (press) begin
          // a coincident tick is not counted: the pre-increment value is the result
          state_d    = DONE;
          reaction_d = count_q;
          if (count_q < best_q) begin
            best_d     = count_q;
            new_best_d = 1'b1;
          end
        end else if (bus.tick) begin
          if (count_q == LAST_C) begin
            state_d    = DONE;
            timeout_d  = 1'b1;
            reaction_d = TIMEOUT_C;
            count_d    = TIMEOUT_C;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      DONE: arm = bus.seq_start;
      default: state_d = IDLE;
    endcase

    if (arm) begin
      state_d    = ARMED;
      count_d    = '0;
      reaction_d = '0;
      jump_d     = 1'b0;
      timeout_d  = 1'b0;
    end

    if (bus.clear_best) begin
      best_d     = '1;
      new_best_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reaction_q <= '0;
      best_q     <= '1;
      jump_q     <= 1'b0;
      timeout_q  <= 1'b0;
      new_best_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reaction_q <= reaction_d;
      best_q     <= best_d;
      jump_q     <= jump_d;
      timeout_q  <= timeout_d;
      new_best_q <= new_best_d;
    end
  end

  assign bus.armed        = (state_q == ARMED) || (state_q == TIMING);
  assign bus.result_valid = (state_q == DONE);
  assign bus.jump_start   = jump_q;
  assign bus.timeout      = timeout_q;
  assign bus.reaction_ms  = reaction_q;
  assign bus.best_ms      = best_q;
  assign bus.new_best     = new_best_q;
endmodule
`default_nettype wire

// File: tb/tb_f1_reaction_timer.sv
`default_nettype none
// tb_f1_reaction_timer: directed table-driven bench for the F1 reaction timer.
// Revision: 1.0
module tb_f1_reaction_timer;
  import f1_pkg::*;

  localparam int CNT_W = 11;
  localparam int TMO   = 1999;
  localparam int NONE  = 2047;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 sysclk = ~sysclk;

  f1_reaction_timer_if #(.CNT_W(CNT_W)) bus ();

  f1_reaction_timer #(.TIMEOUT_MS(TMO), .CNT_W(CNT_W)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int nb_seen = 0;

  always @(negedge sysclk) if (rst_n && bus.new_best === 1'b1) nb_seen++;

  typedef struct {
    bit clr;
    int ticks;
    bit exp_nb;
    int exp_best;
  } run_vec_t;

  run_vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_seq();
    @(posedge sysclk); #1 bus.seq_start = 1'b1;
    @(posedge sysclk); #1 bus.seq_start = 1'b0;
  endtask

  task automatic pulse_lo();
    @(posedge sysclk); #1 bus.lights_out = 1'b1;
    @(posedge sysclk); #1 bus.lights_out = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge sysclk); #1 bus.clear_best = 1'b1;
    @(posedge sysclk); #1 bus.clear_best = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sysclk); #1 bus.tick = 1'b1;
      @(posedge sysclk); #1 bus.tick = 1'b0;
    end
  endtask

  // Raise the button; the result registers three edges later, checked at the next negedge.
  task automatic press_wait();
    bus.button = 1'b1;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic release_btn();
    @(posedge sysclk); #1 bus.button = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
  endtask

  initial begin
    int nb0;
    bus.tick = 0; bus.seq_start = 0; bus.lights_out = 0; bus.button = 0; bus.clear_best = 0;
    vecs[0] = '{1'b1, 300, 1'b1, 300};
    vecs[1] = '{1'b0, 180, 1'b1, 180};
    vecs[2] = '{1'b0, 180, 1'b0, 180};
    vecs[3] = '{1'b0, 250, 1'b0, 180};
    vecs[4] = '{1'b0, 10,  1'b1, 10};

    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk("rst_armed", int'(bus.armed), 0);
    chk("rst_valid", int'(bus.result_valid), 0);
    chk("rst_best", int'(bus.best_ms), NONE);
    chk("rst_react", int'(bus.reaction_ms), 0);
    #1 rst_n = 1'b1;

    // normal reaction
    pulse_seq();
    @(negedge sysclk);
    chk("arm_after_seq", int'(bus.armed), 1);
    pulse_lo();
    ticks(215);
    press_wait();
    chk("norm_valid", int'(bus.result_valid), 1);
    chk("norm_react", int'(bus.reaction_ms), 215);
    chk("norm_jump", int'(bus.jump_start), 0);
    chk("norm_tmo", int'(bus.timeout), 0);
    chk("norm_best", int'(bus.best_ms), 215);
    chk("norm_nb", int'(bus.new_best), 1);
    @(negedge sysclk);
    chk("norm_nb_once", int'(bus.new_best), 0);
    release_btn();

    // jump start, later lights_out ignored
    pulse_seq();
    press_wait();
    chk("jump_flag", int'(bus.jump_start), 1);
    chk("jump_react", int'(bus.reaction_ms), 0);
    chk("jump_best", int'(bus.best_ms), 215);
    pulse_lo();
    @(negedge sysclk);
    chk("jump_lo_valid", int'(bus.result_valid), 1);
    chk("jump_lo_armed", int'(bus.armed), 0);
    release_btn();

    // timeout
    pulse_seq();
    pulse_lo();
    ticks(TMO - 1);
    @(negedge sysclk);
    chk("tmo_not_yet", int'(bus.result_valid), 0);
    ticks(1);
    @(negedge sysclk);
    chk("tmo_valid", int'(bus.result_valid), 1);
    chk("tmo_flag", int'(bus.timeout), 1);
    chk("tmo_react", int'(bus.reaction_ms), TMO);
    chk("tmo_best", int'(bus.best_ms), 215);

    // best tracking table
    nb0 = nb_seen;
    foreach (vecs[i]) begin
      if (vecs[i].clr) begin
        pulse_clr();
        @(negedge sysclk);
        chk("clr_best", int'(bus.best_ms), NONE);
      end
      pulse_seq();
      pulse_lo();
      ticks(vecs[i].ticks);
      press_wait();
      chk($sformatf("tbl%0d_react", i), int'(bus.reaction_ms), vecs[i].ticks);
      chk($sformatf("tbl%0d_nb", i), int'(bus.new_best), int'(vecs[i].exp_nb));
      chk($sformatf("tbl%0d_best", i), int'(bus.best_ms), vecs[i].exp_best);
      release_btn();
      if (i == 3) chk("nb_twice", nb_seen - nb0, 2);
    end
    pulse_clr();
    @(negedge sysclk);
    chk("clr_best2", int'(bus.best_ms), NONE);

    // press in the same cycle as lights_out
    pulse_seq();
    bus.button = 1'b1;
    @(posedge sysclk);
    @(posedge sysclk); #1 bus.lights_out = 1'b1;
    @(posedge sysclk); #1 bus.lights_out = 1'b0;
    @(negedge sysclk);
    chk("sim_lo_jump", int'(bus.jump_start), 1);
    chk("sim_lo_valid", int'(bus.result_valid), 1);
    release_btn();

    // press with tick at count 99
    pulse_seq();
    pulse_lo();
    ticks(99);
    bus.button = 1'b1;
    @(posedge sysclk);
    @(posedge sysclk); #1 bus.tick = 1'b1;
    @(posedge sysclk); #1 bus.tick = 1'b0;
    @(negedge sysclk);
    chk("sim_tick_react", int'(bus.reaction_ms), 99);
    chk("sim_tick_valid", int'(bus.result_valid), 1);
    release_btn();

    // press with the final tick wins
    pulse_seq();
    pulse_lo();
    ticks(TMO - 1);
    bus.button = 1'b1;
    @(posedge sysclk);
    @(posedge sysclk); #1 bus.tick = 1'b1;
    @(posedge sysclk); #1 bus.tick = 1'b0;
    @(negedge sysclk);
    chk("last_tick_react", int'(bus.reaction_ms), TMO - 1);
    chk("last_tick_tmo", int'(bus.timeout), 0);
    release_btn();

    // held button across two runs
    pulse_seq();
    pulse_lo();
    ticks(10);
    press_wait();
    chk("held_r1", int'(bus.reaction_ms), 10);
    pulse_seq();
    pulse_lo();
    ticks(5);
    repeat (4) @(posedge sysclk);
    @(negedge sysclk);
    chk("held_no_press", int'(bus.result_valid), 0);
    chk("held_armed", int'(bus.armed), 1);
    release_btn();
    press_wait();
    chk("held_r2", int'(bus.reaction_ms), 5);
    release_btn();

    // asynchronous reset mid-TIMING
    pulse_seq();
    pulse_lo();
    ticks(50);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_armed", int'(bus.armed), 0);
    chk("arst_valid", int'(bus.result_valid), 0);
    chk("arst_best", int'(bus.best_ms), NONE);
    chk("arst_react", int'(bus.reaction_ms), 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    pulse_lo();
    press_wait();
    repeat (2) @(negedge sysclk);
    chk("idle_ign_valid", int'(bus.result_valid), 0);
    chk("idle_ign_armed", int'(bus.armed), 0);
    release_btn();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
